// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the 8-source interrupt controller: FSM states,
// source/ID sizing and the ID-to-one-hot helper.
package irq_ctrl_pkg;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  function automatic logic [NUM_SRC-1:0] id2onehot(input logic [ID_W-1:0] id);
    return NUM_SRC'(1) << id;
  endfunction

endpackage

// File: rtl/irq_ctrl8_prio_enc8.sv
// Combinational 8-to-3 priority encoder; the highest set index wins and
// valid flags that any request bit is set.
module prio_enc8
  import irq_ctrl_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Ascending scan so the last (highest) set bit overwrites lower ones.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl8.sv
// Eight-source edge-triggered interrupt controller with mask register,
// fixed highest-index priority and an IDLE/REQ/SERVICE handshake FSM.
module irq_ctrl8
  import irq_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_SRC-1:0]  irq,
  input  logic                mask_we,
  input  logic [NUM_SRC-1:0]  mask_wdata,
  input  logic                int_ack,
  input  logic                eoi,
  output logic                int_req,
  output logic [ID_W-1:0]     int_id,
  output logic [NUM_SRC-1:0]  pending,
  output logic [NUM_SRC-1:0]  in_service,
  output logic [NUM_SRC-1:0]  mask
);

  state_t               state_q, state_d;
  logic [NUM_SRC-1:0]   irq_q;
  logic [NUM_SRC-1:0]   pending_q;
  logic [NUM_SRC-1:0]   in_service_q;
  logic [NUM_SRC-1:0]   mask_q;
  logic [ID_W-1:0]      int_id_q;

  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   eligible;
  logic [NUM_SRC-1:0]   mask_eff;
  logic [NUM_SRC-1:0]   pend_clr;
  logic                 sel_vld;
  logic [ID_W-1:0]      sel_idx;
  logic                 ld_id;
  logic                 ack_fire;
  logic                 eoi_fire;

  assign rise     = irq & ~irq_q;
  assign eligible = pending_q & ~mask_q;
  // Mask as it will be after this edge, so a write cancels REQ immediately.
  assign mask_eff = mask_we ? mask_wdata : mask_q;
  assign pend_clr = ack_fire ? id2onehot(int_id_q) : '0;

  prio_enc8 u_prio (
    .req   (eligible),
    .valid (sel_vld),
    .idx   (sel_idx)
  );

  always_comb begin
    state_d  = state_q;
    ld_id    = 1'b0;
    ack_fire = 1'b0;
    eoi_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_vld) begin
          state_d = ST_REQ;
          ld_id   = 1'b1;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          state_d  = ST_SERVICE;
          ack_fire = 1'b1;
        end else if (mask_eff[int_id_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          state_d  = ST_IDLE;
          eoi_fire = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q        <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= '1;
      int_id_q     <= '0;
    end else begin
      irq_q <= irq;
      if (mask_we) mask_q <= mask_wdata;
      // A new edge is OR-ed in after the clear, so a simultaneous set wins.
      pending_q <= (pending_q & ~pend_clr) | rise;
      if (ld_id) int_id_q <= sel_idx;
      if (ack_fire)      in_service_q <= id2onehot(int_id_q);
      else if (eoi_fire) in_service_q <= '0;
    end
  end

  assign int_req    = (state_q == ST_REQ);
  assign int_id     = int_id_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign mask       = mask_q;

endmodule

// File: tb/tb_irq_ctrl8.sv
// Scenario bench for irq_ctrl8: expected service IDs are queued when sources
// are raised and popped as the controller presents each interrupt.
module tb_irq_ctrl8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] irq;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       int_ack;
  logic       eoi;
  logic       int_req;
  logic [2:0] int_id;
  logic [7:0] pending;
  logic [7:0] in_service;
  logic [7:0] mask;

  int tests_run = 0;
  int tests_failed = 0;
  logic [2:0] exp_q[$];

  irq_ctrl8 dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_ack    (int_ack),
    .eoi        (eoi),
    .int_req    (int_req),
    .int_id     (int_id),
    .pending    (pending),
    .in_service (in_service),
    .mask       (mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we = 1'b1;
    mask_wdata = m;
    tick();
    mask_we = 1'b0;
  endtask

  // Waits for the next presented interrupt, checks it against the queue
  // head, then acknowledges and ends it.
  task automatic serve_next(input string tag);
    logic [2:0] exp_id;
    logic [7:0] exp_oh;
    int waited;
    waited = 0;
    while (int_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
    exp_oh = 8'h01 << exp_id;
    tests_run++;
    if (int_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_timeout: int_req=%b required 1 within 20 cycles", tag, int_req);
      return;
    end
    tests_run++;
    if (int_id !== exp_id) begin
      tests_failed++;
      $display("FAIL %s_id: int_id=%0d required %0d", tag, int_id, exp_id);
    end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    tests_run++;
    if (in_service !== exp_oh || int_req !== 1'b0 || (pending & exp_oh) !== 8'h00) begin
      tests_failed++;
      $display("FAIL %s_ack: in_service=%h int_req=%b pending=%h required in_service=%h int_req=0 pending bit clear",
               tag, in_service, int_req, pending, exp_oh);
    end
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tests_run++;
    if (in_service !== 8'h00 || int_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_eoi: in_service=%h int_req=%b required 00/0", tag, in_service, int_req);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    irq = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00; int_ack = 1'b0; eoi = 1'b0;
    tick(); tick();
    tests_run++;
    if (pending !== 8'h00 || in_service !== 8'h00 || mask !== 8'hFF || int_req !== 1'b0 || int_id !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset: pending=%h in_service=%h mask=%h int_req=%b int_id=%0d required 00/00/FF/0/0",
               pending, in_service, mask, int_req, int_id);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    write_mask(8'h00);
    tests_run++;
    if (mask !== 8'h00) begin
      tests_failed++;
      $display("FAIL basic_mask: mask=%h required 00", mask);
    end
    irq = 8'h04;
    exp_q.push_back(3'd2);
    tick();
    tests_run++;
    if (pending !== 8'h04 || int_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_pend: pending=%h int_req=%b required 04/0", pending, int_req);
    end
    irq = 8'h00;
    tick();
    tests_run++;
    if (int_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_latency: int_req=%b required 1 two cycles after edge", int_req);
    end
    serve_next("basic");
  endtask

  task automatic test_priority();
    irq = 8'h62;
    exp_q.push_back(3'd6);
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd1);
    tick();
    irq = 8'h00;
    serve_next("prio_a");
    tests_run++;
    if (pending !== 8'h22) begin
      tests_failed++;
      $display("FAIL prio_left: pending=%h required 22", pending);
    end
    serve_next("prio_b");
    serve_next("prio_c");
  endtask

  task automatic test_mask();
    write_mask(8'h40);
    irq = 8'h48;
    exp_q.push_back(3'd3);
    tick();
    irq = 8'h00;
    tests_run++;
    if (pending !== 8'h48) begin
      tests_failed++;
      $display("FAIL mask_collect: pending=%h required 48", pending);
    end
    tick(); tick();
    tests_run++;
    if (int_req !== 1'b1 || int_id !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL mask_sel: int_req=%b int_id=%0d required 1/3", int_req, int_id);
    end
    void'(exp_q.pop_front());
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    write_mask(8'h00);
    tests_run++;
    if (in_service !== 8'h08 || pending !== 8'h40) begin
      tests_failed++;
      $display("FAIL mask_svc: in_service=%h pending=%h required 08/40", in_service, pending);
    end
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    exp_q.push_back(3'd6);
    serve_next("mask_next");
  endtask

  task automatic test_mask_in_req();
    irq = 8'h10;
    tick();
    irq = 8'h00;
    tick();
    tests_run++;
    if (int_req !== 1'b1 || int_id !== 3'd4) begin
      tests_failed++;
      $display("FAIL mreq_enter: int_req=%b int_id=%0d required 1/4", int_req, int_id);
    end
    write_mask(8'h10);
    tests_run++;
    if (int_req !== 1'b0 || pending !== 8'h10) begin
      tests_failed++;
      $display("FAIL mreq_drop: int_req=%b pending=%h required 0/10", int_req, pending);
    end
    tick();
    tests_run++;
    if (int_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL mreq_hold: int_req=%b required 0 while masked", int_req);
    end
    write_mask(8'h00);
    exp_q.push_back(3'd4);
    serve_next("mreq_unmask");
  endtask

  task automatic test_ack_set_wins();
    irq = 8'h08;
    tick();
    irq = 8'h00;
    tick();
    irq = 8'h08;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    irq = 8'h00;
    tests_run++;
    if (pending !== 8'h08 || in_service !== 8'h08) begin
      tests_failed++;
      $display("FAIL setwins: pending=%h in_service=%h required 08/08", pending, in_service);
    end
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    exp_q.push_back(3'd3);
    serve_next("setwins_again");
  endtask

  task automatic test_reset_mid();
    irq = 8'h20;
    tick();
    irq = 8'h00;
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    irq = 8'h21;
    tick();
    irq = 8'h80;
    tests_run++;
    if (pending !== 8'h21 || in_service !== 8'h20) begin
      tests_failed++;
      $display("FAIL rmid_setup: pending=%h in_service=%h required 21/20", pending, in_service);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (pending !== 8'h00 || in_service !== 8'h00 || mask !== 8'hFF || int_req !== 1'b0 || int_id !== 3'd0) begin
      tests_failed++;
      $display("FAIL rmid_async: pending=%h in_service=%h mask=%h int_req=%b int_id=%0d required 00/00/FF/0/0",
               pending, in_service, mask, int_req, int_id);
    end
    tick();
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (pending !== 8'h80 || int_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL rel_edge: pending=%h int_req=%b required 80/0", pending, int_req);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_mask_in_req();
    test_ack_set_wins();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/irq_ctrl8.md
IRQ_CTRL8 -- requirements
Module: irq_ctrl8

Interface
REQ-001 Parameters: none; the source count SHALL be fixed at 8 and the ID width at 3.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 irq  in  8  interrupt source lines, synchronous to clk; a rising edge requests service.
REQ-005 mask_we  in  1  write strobe for the mask register.
REQ-006 mask_wdata  in  8  new mask value; 1 = source masked.
REQ-007 int_ack  in  1  CPU accepts the presented interrupt.
REQ-008 eoi  in  1  CPU signals end of the in-service interrupt.
REQ-009 int_req  out  1  interrupt presented to the CPU.
REQ-010 int_id  out  3  index of the presented or in-service source.
REQ-011 pending  out  8  pending register.
REQ-012 in_service  out  8  in-service register, one-hot or zero.
REQ-013 mask  out  8  current mask register.

Function
REQ-014 Edge detect: pending[i] SHALL set at edge k when irq[i]=1 at k and irq_q[i]=0, where irq_q is irq registered at edge k-1.
REQ-015 A further edge on a bit that is already pending SHALL leave it pending once; edges are not counted.
REQ-016 Eligible = pending & ~mask. The selected source SHALL be the highest eligible index (bit 7 highest).
REQ-017 Selection SHALL be encoded to 3-bit binary.
REQ-018 FSM states are IDLE, REQ and SERVICE.
REQ-019 IDLE: if eligible != 0 at an edge, the FSM SHALL move to REQ and latch int_id = selected index at that edge; otherwise it stays in IDLE.
REQ-020 REQ: int_req=1 and int_id SHALL be held stable.
REQ-021 REQ with int_ack=1: pending[int_id] SHALL clear, in_service[int_id] SHALL set, and the FSM SHALL move to SERVICE.
REQ-022 REQ with int_ack=0 and mask[int_id] becoming 1 (a mask write that takes effect): int_req SHALL drop next cycle, the FSM SHALL return to IDLE, and pending SHALL be kept.
REQ-023 A higher-priority source becoming eligible during REQ SHALL NOT change int_id; there is no preemption.
REQ-024 SERVICE: int_req=0 and int_id SHALL hold the in-service index.
REQ-025 SERVICE with eoi=1: in_service SHALL clear to 0 and the FSM SHALL return to IDLE.
REQ-026 eoi outside SERVICE and int_ack outside REQ SHALL be ignored.
REQ-027 Same-edge set and clear of one pending bit (new edge plus ack): set SHALL win, so the bit stays pending.
REQ-028 Latency: a rising edge on irq sampled at edge k SHALL give int_req=1 after edge k+1 (two cycles), given IDLE and the source unmasked.
REQ-029 A mask write SHALL take effect at the edge where mask_we=1. A masked source SHALL keep collecting pending bits.
REQ-030 Back-to-back: IDLE after eoi SHALL re-evaluate eligibility on the next edge, so there is a minimum of one IDLE cycle between interrupts.

Reset
REQ-031 reset_n=0 SHALL immediately force: state=IDLE, pending=0, in_service=0, mask=8'hFF (all masked), irq_q=0, int_req=0, int_id=0.
REQ-032 Reset asserted mid-REQ or mid-SERVICE SHALL abandon the interrupt with no residual pending or in-service bit.
REQ-033 A source already high at reset release SHALL register one edge on the first clock.

Structure
REQ-034 Shared package irq_ctrl_pkg SHALL hold the FSM state enum and the constants NUM_SRC=8 and ID_W=3.
REQ-035 Sub-module prio_enc8 SHALL be the combinational 8-to-3 highest-index priority encoder with a valid output. All other logic stays in irq_ctrl8.

Verification
REQ-036 Reset, then mask write 8'h00, then pulse irq[2] -> int_req=1 two cycles later with int_id=2; ack -> pending=0, in_service=8'h04; eoi -> in_service=0, FSM in IDLE.
REQ-037 irq[1], irq[5] and irq[6] rise on the same edge, mask 8'h00 -> served in order 6, 5, 1, each after its predecessor's eoi.
REQ-038 mask 8'h40, irq[6] and irq[3] rise -> int_id=3. Then mask write 8'h00 and eoi -> next int_id=6.
REQ-039 In REQ with int_id=4, write mask 8'h10 -> int_req=0 next cycle, pending[4] stays 1; unmask -> int_req reasserts with int_id=4.
REQ-040 Ack of id 3 on the same edge that irq[3] re-rises -> pending[3]=1, in_service=8'h08.
REQ-041 Assert reset_n=0 in SERVICE with pending=8'h21 -> all outputs at reset values within the same cycle, mask=8'hFF.
